// File: rtl/jtag_pkg.sv
// Shared JTAG TDR definitions: capture-mode encodings and shift-count qualifier states.
package jtag_pkg;

  localparam int unsigned CAP_CONST    = 0;
  localparam int unsigned CAP_PARALLEL = 1;

  localparam logic [1:0] UNDER = 2'd0;
  localparam logic [1:0] EXACT = 2'd1;
  localparam logic [1:0] OVER  = 2'd2;

endpackage

// File: rtl/dr_shift_counter.sv
// Saturating shift counter: clears on capture, counts shifts up to DR_LENGTH+1,
// and tracks whether the count is under, exactly at, or over the register length.
module dr_shift_counter
  import jtag_pkg::*;
#(
  parameter int unsigned DR_LENGTH = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clr,
  input  logic                              inc,
  output logic [$clog2(DR_LENGTH+2)-1:0]    count,
  output logic                              exact
);

  localparam int unsigned CW = $clog2(DR_LENGTH + 2);
  localparam logic [CW-1:0] LEN = CW'(DR_LENGTH);
  localparam logic [CW-1:0] SAT = CW'(DR_LENGTH + 1);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] count_nxt;

  // Next count and its qualifier; OVER is sticky until the next clear.
  always_comb begin
    count_nxt = count;
    state_nxt = state;
    if (clr) begin
      count_nxt = '0;
    end else if (inc && (state != OVER)) begin
      count_nxt = count + CW'(1);
    end
    if (count_nxt == SAT) begin
      state_nxt = OVER;
    end else if (count_nxt == LEN) begin
      state_nxt = EXACT;
    end else begin
      state_nxt = UNDER;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      state <= UNDER;
      exact <= 1'b0;
    end else begin
      count <= count_nxt;
      state <= state_nxt;
      exact <= (state_nxt == EXACT);
    end
  end

endmodule

// File: rtl/jtag_param_tdr.sv
// Parametrised JTAG test data register with configurable capture source,
// resettable update register and a shift-length check that gates the update.
module jtag_param_tdr
  import jtag_pkg::*;
#(
  parameter int unsigned           DR_LENGTH          = 8,
  parameter int unsigned           CAPTURE_MODE       = CAP_CONST,
  parameter logic [DR_LENGTH-1:0]  CAPTURE_VALUE      = '1,
  parameter logic [DR_LENGTH-1:0]  UPDATE_RESET_VALUE = '0,
  parameter bit                    CHECK_LENGTH       = 1'b1
) (
  input  logic                              TCK,
  input  logic                              RST,
  input  logic                              tdr_Select,
  input  logic                              Capture_DR,
  input  logic                              Shift_DR,
  input  logic                              Update_DR,
  input  logic                              TDI,
  input  logic [DR_LENGTH-1:0]              PI,
  output logic                              SO_DR_OUT,
  output logic [DR_LENGTH-1:0]              PO,
  output logic                              Update_Valid,
  output logic                              Length_Err,
  output logic [$clog2(DR_LENGTH+2)-1:0]    Shift_Count
);

  logic [DR_LENGTH-1:0] shift_reg;
  logic [DR_LENGTH-1:0] cap_val;
  logic                 do_cap;
  logic                 do_shift;
  logic                 do_upd;
  logic                 accept;
  logic                 exact;
  logic                 upd_prev;

  // Strobe priority: capture over shift over update, all qualified by select.
  assign do_cap   = tdr_Select & Capture_DR;
  assign do_shift = tdr_Select & Shift_DR & ~Capture_DR;
  assign do_upd   = tdr_Select & Update_DR & ~Capture_DR & ~Shift_DR;
  assign accept   = do_upd & (!CHECK_LENGTH || exact);

  assign cap_val   = (CAPTURE_MODE == CAP_PARALLEL) ? PI : CAPTURE_VALUE;
  assign SO_DR_OUT = shift_reg[DR_LENGTH-1];

  dr_shift_counter #(
    .DR_LENGTH (DR_LENGTH)
  ) u_cnt (
    .clk   (TCK),
    .rst   (RST),
    .clr   (do_cap),
    .inc   (do_shift),
    .count (Shift_Count),
    .exact (exact)
  );

  always_ff @(posedge TCK) begin
    if (RST) begin
      shift_reg <= '0;
    end else if (do_cap) begin
      shift_reg <= cap_val;
    end else if (do_shift) begin
      shift_reg <= {shift_reg[DR_LENGTH-2:0], TDI};
    end
  end

  // A held update re-evaluates each edge but only its first accepted edge pulses.
  always_ff @(posedge TCK) begin
    if (RST) begin
      PO           <= UPDATE_RESET_VALUE;
      Update_Valid <= 1'b0;
      Length_Err   <= 1'b0;
      upd_prev     <= 1'b0;
    end else begin
      Update_Valid <= accept & ~upd_prev;
      upd_prev     <= do_upd;
      if (do_cap) begin
        Length_Err <= 1'b0;
      end else if (do_upd) begin
        if (accept) begin
          PO         <= shift_reg;
          Length_Err <= 1'b0;
        end else begin
          Length_Err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_param_tdr.sv
// Scoreboard bench for jtag_param_tdr: two instances (checked parallel-capture,
// unchecked constant-capture) share stimulus; a queue model predicts every cycle.
module tb_jtag_param_tdr;
  import jtag_pkg::*;

  localparam int unsigned L  = 8;
  localparam int unsigned CW = $clog2(L + 2);
  localparam logic [7:0]  CONST_B = 8'hC3;
  localparam logic [7:0]  RST_A   = 8'hA5;

  typedef struct packed {
    logic [1:0]          so;
    logic [1:0][7:0]     po;
    logic [1:0]          uv;
    logic [1:0]          le;
    logic [1:0][CW-1:0]  cnt;
  } exp_t;

  logic          TCK = 1'b0;
  logic          RST = 1'b1;
  logic          sel = 1'b0, cap = 1'b0, shf = 1'b0, upd = 1'b0, tdi = 1'b0;
  logic [7:0]    pi = '0;
  logic          so_a, so_b, uv_a, uv_b, le_a, le_b;
  logic [7:0]    po_a, po_b;
  logic [CW-1:0] cnt_a, cnt_b;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];

  // Reference model state, index 0 = instance a, 1 = instance b.
  logic [7:0] m_sr[2];
  logic [7:0] m_po[2];
  logic       m_uv[2];
  logic       m_le[2];
  int         m_cnt[2];
  logic       m_hold[2];

  always #5 TCK = ~TCK;

  jtag_param_tdr #(
    .DR_LENGTH(L), .CAPTURE_MODE(CAP_PARALLEL), .CAPTURE_VALUE(8'hFF),
    .UPDATE_RESET_VALUE(RST_A), .CHECK_LENGTH(1'b1)
  ) u_dut_a (
    .TCK(TCK), .RST(RST), .tdr_Select(sel), .Capture_DR(cap), .Shift_DR(shf),
    .Update_DR(upd), .TDI(tdi), .PI(pi), .SO_DR_OUT(so_a), .PO(po_a),
    .Update_Valid(uv_a), .Length_Err(le_a), .Shift_Count(cnt_a)
  );

  jtag_param_tdr #(
    .DR_LENGTH(L), .CAPTURE_MODE(CAP_CONST), .CAPTURE_VALUE(CONST_B),
    .UPDATE_RESET_VALUE(8'h00), .CHECK_LENGTH(1'b0)
  ) u_dut_b (
    .TCK(TCK), .RST(RST), .tdr_Select(sel), .Capture_DR(cap), .Shift_DR(shf),
    .Update_DR(upd), .TDI(tdi), .PI(pi), .SO_DR_OUT(so_b), .PO(po_b),
    .Update_Valid(uv_b), .Length_Err(le_b), .Shift_Count(cnt_b)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and push the model's post-edge prediction.
  task automatic step(input bit r, input bit s, input bit c, input bit sh,
                      input bit u, input bit t, input logic [7:0] p);
    exp_t e;
    bit   check;
    bit   acted;
    @(negedge TCK);
    RST = r; sel = s; cap = c; shf = sh; upd = u; tdi = t; pi = p;
    for (int i = 0; i < 2; i++) begin
      check = (i == 0);
      acted = 1'b0;
      m_uv[i] = 1'b0;
      if (r) begin
        m_sr[i] = '0; m_po[i] = (i == 0) ? RST_A : 8'h00;
        m_le[i] = 1'b0; m_cnt[i] = 0; m_hold[i] = 1'b0;
      end else begin
        if (s && c) begin
          m_sr[i] = (i == 0) ? p : CONST_B;
          m_cnt[i] = 0;
          m_le[i] = 1'b0;
        end else if (s && sh) begin
          m_sr[i] = {m_sr[i][6:0], t};
          if (m_cnt[i] < L + 1) m_cnt[i]++;
        end else if (s && u) begin
          acted = 1'b1;
          if (!check || m_cnt[i] == L) begin
            m_po[i] = m_sr[i];
            m_le[i] = 1'b0;
            m_uv[i] = !m_hold[i];
          end else begin
            m_le[i] = 1'b1;
          end
        end
        m_hold[i] = acted;
      end
      e.so[i]  = m_sr[i][7];
      e.po[i]  = m_po[i];
      e.uv[i]  = m_uv[i];
      e.le[i]  = m_le[i];
      e.cnt[i] = CW'(m_cnt[i]);
    end
    sb.push_back(e);
  endtask

  task automatic after_edge();
    @(posedge TCK);
    #2;
  endtask

  task automatic scan(input logic [7:0] p, input int n, input int holds);
    step(0, 1, 1, 0, 0, 0, p);
    for (int k = 0; k < n; k++) step(0, 1, 0, 1, 0, 1'($urandom), p);
    for (int k = 0; k < holds; k++) step(0, 1, 0, 0, 1, 0, p);
    step(0, 1, 0, 0, 0, 0, p);
  endtask

  // Monitor: compare every DUT output against the queued prediction each cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge TCK);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("so_a",  8'(so_a),  8'(e.so[0]));
        chk("so_b",  8'(so_b),  8'(e.so[1]));
        chk("po_a",  po_a,      e.po[0]);
        chk("po_b",  po_b,      e.po[1]);
        chk("uv_a",  8'(uv_a),  8'(e.uv[0]));
        chk("uv_b",  8'(uv_b),  8'(e.uv[1]));
        chk("le_a",  8'(le_a),  8'(e.le[0]));
        chk("le_b",  8'(le_b),  8'(e.le[1]));
        chk("cnt_a", 8'(cnt_a), 8'(e.cnt[0]));
        chk("cnt_b", 8'(cnt_b), 8'(e.cnt[1]));
      end
    end
  end

  initial begin : stimulus
    logic [7:0] pat;
    bit r, s, c, sh, u;
    pat = 8'b10110010;

    step(1, 0, 0, 0, 0, 0, 8'h00);
    step(1, 0, 0, 0, 0, 0, 8'h00);
    after_edge();
    chk("reset_po", po_a, RST_A);
    chk("reset_so", 8'(so_a), 8'h00);

    // Exact scan with parallel capture, update held three cycles.
    step(0, 1, 1, 0, 0, 0, 8'h3C);
    for (int k = 0; k < 8; k++) step(0, 1, 0, 1, 0, pat[7-k], 8'h3C);
    step(0, 1, 0, 0, 1, 0, 8'h3C);
    after_edge();
    chk("exact_po", po_a, 8'hB2);
    chk("exact_uv", 8'(uv_a), 8'h01);
    step(0, 1, 0, 0, 1, 0, 8'h3C);
    step(0, 1, 0, 0, 1, 0, 8'h3C);
    step(0, 1, 0, 0, 0, 0, 8'h3C);

    // Undershift, then overshift.
    scan(8'h5E, 7, 1);
    scan(8'h81, 12, 1);
    after_edge();
    chk("over_cnt", 8'(cnt_a), 8'd9);
    chk("over_le", 8'(le_a), 8'h01);

    // Short scan: instance b accepts unchecked, instance a rejects.
    step(0, 1, 1, 0, 0, 0, 8'h00);
    step(0, 1, 0, 1, 0, 1, 8'h00);
    step(0, 1, 0, 1, 0, 1, 8'h00);
    step(0, 1, 0, 1, 0, 0, 8'h00);
    step(0, 1, 0, 0, 1, 0, 8'h00);
    after_edge();
    chk("unchk_po", po_b, 8'h1E);
    chk("unchk_le", 8'(le_b), 8'h00);

    // Capture with update together, then strobes while deselected.
    step(0, 1, 1, 0, 1, 0, 8'h77);
    step(0, 0, 1, 0, 0, 0, 8'h12);
    step(0, 0, 0, 1, 0, 1, 8'h12);
    step(0, 0, 0, 0, 1, 0, 8'h12);
    step(0, 1, 0, 0, 0, 0, 8'h12);

    // Reset mid-scan, then an update with no fresh capture.
    step(0, 1, 1, 0, 0, 0, 8'hF0);
    for (int k = 0; k < 4; k++) step(0, 1, 0, 1, 0, 1'($urandom), 8'hF0);
    step(1, 1, 0, 1, 0, 1, 8'hF0);
    step(0, 1, 0, 0, 1, 0, 8'hF0);
    after_edge();
    chk("midrst_po", po_a, RST_A);
    chk("midrst_le", 8'(le_a), 8'h01);

    // Random near-length scans.
    for (int n = 0; n < 30; n++)
      scan(8'($urandom), $urandom_range(6, 10), $urandom_range(1, 2));

    // Fully random strobes.
    for (int n = 0; n < 400; n++) begin
      r  = ($urandom_range(0, 39) == 0);
      s  = ($urandom_range(0, 9) != 0);
      c  = ($urandom_range(0, 5) == 0);
      sh = 1'($urandom_range(0, 1));
      u  = ($urandom_range(0, 3) == 0);
      step(r, s, c, sh, u, 1'($urandom), 8'($urandom));
    end

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge TCK);
    #3;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jtag_param_tdr.md
# jtag_param_tdr

Parametrised JTAG test data register: the generalised successor to the fixed-length bypass-style DR. It supports a configurable length and a capture source that is either a constant or a parallel input. It has a resettable parallel update output and a shift-length checker that blocks the update on any scan whose bit count is wrong. It sits behind the TAP controller, is selected by the instruction decoder via `tdr_Select`, and drives one leg of the TDO mux.

## Interface
- `DR_LENGTH`, 8: number of register bits; must be ≥ 2.
- `CAPTURE_MODE`, 0: 0 captures `CAPTURE_VALUE`; 1 captures `PI`.
- `CAPTURE_VALUE`, all-ones: constant loaded on capture when `CAPTURE_MODE`=0.
- `UPDATE_RESET_VALUE`, 0: reset value of `PO`.
- `CHECK_LENGTH`, 1: 1 gates the update on an exact shift count; 0 makes every update unconditional.

Ports:
- `TCK` input 1: sole clock; all state changes on the rising edge.
- `RST` input 1: reset; synchronous, active-high.
- `tdr_Select` input 1: register selected; all strobes are ignored when low.
- `Capture_DR` input 1: capture strobe from the TAP.
- `Shift_DR` input 1: shift strobe from the TAP.
- `Update_DR` input 1: update strobe from the TAP.
- `TDI` input 1: serial data in.
- `PI` input DR_LENGTH: parallel capture data.
- `SO_DR_OUT` output 1: serial out, equal to shift register MSB.
- `PO` output DR_LENGTH: update register, the parallel output to the design.
- `Update_Valid` output 1: one-cycle pulse when `PO` is loaded.
- `Length_Err` output 1: last update was rejected because of a wrong shift count.
- `Shift_Count` output $clog2(DR_LENGTH+2): shifts since the last capture, saturating.

## Operation
- Strobes are acted on only while `tdr_Select`=1.
- Strobe priority: Capture > Shift > Update. Only the highest-priority asserted strobe acts in a given cycle.
- **Capture:**
  - `shift_reg` ← `CAPTURE_VALUE` (mode 0) or `PI` (mode 1).
  - `Shift_Count` ← 0.
  - `Length_Err` ← 0.
- **Shift:**
  - `shift_reg` ← {`shift_reg[DR_LENGTH-2:0]`, `TDI`}, so MSB goes out first and `TDI` enters at the LSB.
  - `Shift_Count` increments and saturates at DR_LENGTH+1. The value DR_LENGTH+1 means overshift.
- **Update, accepted:** when `CHECK_LENGTH`=0 or `Shift_Count`==DR_LENGTH:
  - `PO` ← `shift_reg`.
  - `Update_Valid` pulses.
  - `Length_Err` ← 0.
- **Update, rejected:** otherwise:
  - `PO` holds.
  - `Update_Valid` stays 0.
  - `Length_Err` ← 1.
- The shift counter is a 3-state qualifier: UNDER (<DR_LENGTH), EXACT (==DR_LENGTH), OVER (saturated at DR_LENGTH+1).
- After reset the state is UNDER, so an update with no capture and shift before it is rejected when `CHECK_LENGTH`=1.
- `shift_reg` and `Shift_Count` hold through an update and through deselection. A second update without a new capture re-evaluates the same count.
- `SO_DR_OUT` is driven continuously from the `shift_reg` MSB, independent of `tdr_Select`; the TDO mux qualifies it.

## Timing
- **Reset:** `RST`=1 at a rising edge sets:
  - `shift_reg` ← 0, so `SO_DR_OUT`=0.
  - `PO` ← `UPDATE_RESET_VALUE`.
  - `Shift_Count`, `Update_Valid` and `Length_Err` ← 0.
- Reset overrides every strobe in the same cycle. A reset in the middle of a scan discards the partial shift.
- **Capture:** `SO_DR_OUT` shows the captured MSB after the capture edge.
- **Shift:** each shift edge presents the next bit on `SO_DR_OUT`. Bit k of the captured value appears after DR_LENGTH-1-k shifts.
- **Update:** `PO`, `Update_Valid` and `Length_Err` change on the edge that samples `Update_DR`.
  - `Update_Valid` is high for exactly one cycle, even if `Update_DR` is held.
  - An update held over several cycles re-evaluates on every edge.
- **Simultaneous strobes:** capture and update in the same cycle performs the capture only. `PO` is unchanged and `Length_Err` ← 0.

## Structure
- Shared package `jtag_pkg` holds:
  - the capture-mode encodings `CAP_CONST` = 0 and `CAP_PARALLEL` = 1;
  - the count-state localparams UNDER, EXACT and OVER.
- One sub-module: `dr_shift_counter`. It implements the saturating count with clear, increment and saturate, and outputs `Shift_Count` and an `exact` flag, parametrised by DR_LENGTH.
- The shift and update registers live in the top module.

## Test plan
- **Reset values:** `DR_LENGTH`=8, `UPDATE_RESET_VALUE`=8'hA5, `RST` held 2 cycles -> `PO`=8'hA5, `SO_DR_OUT`=0, `Shift_Count`=0, `Length_Err`=0, `Update_Valid`=0.
- **Mode-1 exact scan:** capture with `PI`=8'h3C, 8 shifts of TDI=1,0,1,1,0,0,1,0 (first bit first) -> `SO_DR_OUT` sequence 0,0,1,1,1,1,0,0. Then update -> `PO`=8'b10110010 (first TDI bit in the MSB), `Update_Valid` pulses 1 cycle.
- **Undershift and overshift:** 7 shifts then update -> `PO` unchanged and `Length_Err`=1. Recapture, 12 shifts then update -> `Shift_Count`=9 and `Length_Err`=1.
- **Unchecked mode:** `CHECK_LENGTH`=0, capture, 3 shifts, update -> `PO` loads `shift_reg` and `Length_Err` stays 0.
- **Strobe priority:** `Capture_DR` and `Update_DR` asserted together -> capture only and `PO` unchanged. With `tdr_Select`=0, strobes -> no state change.
- **Mid-scan reset:** `RST` after 4 of 8 shifts -> all values return to reset. A following update with no new capture is rejected.
